prog_run_sequencer: RTL and testbench

- Controller that stages a RISC-V CPU run: holds the CPU in reset and preloads NUM_WORDS parameter words into data memory through the CPU's external memory port.
- Releases the CPU, watches its store bus for a result store and a done-flag store, then re-asserts CPU reset.
- Sits between a host/loader stream and the CPU top's Ext_* port and MemWrite/DataAdr/WriteData outputs.

---
 rtl/prog_run_sequencer.sv | 157 +++++++++++++++
 tb/tb_prog_run_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_run_sequencer.sv
// Stages a CPU run: holds the CPU in reset while preloading parameter words,
// releases it, then watches its store bus for the result and done-flag mailboxes.
module prog_run_sequencer #(
  parameter int          NUM_WORDS  = 5,
  parameter logic [31:0] BASE_ADR   = 32'h0200_0000,
  parameter logic [31:0] RESULT_OFS = 32'h0000_000c,
  parameter logic [31:0] DONE_OFS   = 32'h0000_0010,
  parameter int          RST_HOLD   = 2,
  parameter int          TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        cpu_reset,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  input  logic [31:0] DataAdr,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        done,
  output logic        timeout,
  output logic        busy
);

  localparam int          IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);
  localparam int          HOLD_LAST = (RST_HOLD > 0) ? RST_HOLD - 1 : 0;
  localparam logic [31:0] RES_ADR   = BASE_ADR + RESULT_OFS;
  localparam logic [31:0] DONE_ADR  = BASE_ADR + DONE_OFS;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GAP, S_HOLD, S_RUN, S_DONE, S_TOUT
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      wd_q, wd_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      result_q, result_d;
  logic             rv_q, rv_d;
  logic             done_q, done_d;
  logic             tout_q, tout_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      wd_q     <= '0;
      adr_q    <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
      done_q   <= 1'b0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      wd_q     <= wd_d;
      adr_q    <= adr_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      done_q   <= done_d;
      tout_q   <= tout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    // Ext_* default to zero so every write is a single-cycle registered pulse.
    we_d     = 1'b0;
    wd_d     = '0;
    adr_d    = '0;
    result_d = result_q;
    rv_d     = rv_q;
    done_d   = done_q;
    tout_d   = tout_q;
    case (state_q)
      S_IDLE, S_DONE, S_TOUT: begin
        if (start) begin
          state_d  = S_LOAD;
          idx_d    = '0;
          result_d = '0;
          rv_d     = 1'b0;
          done_d   = 1'b0;
          tout_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          we_d    = 1'b1;
          wd_d    = ld_data;
          adr_d   = BASE_ADR + (32'(idx_q) << 2);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = '0;
        if (idx_q == IDX_LAST) begin
          state_d = S_HOLD;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_LOAD;
        end
      end
      S_HOLD: begin
        if (cnt_q == 32'(HOLD_LAST)) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 32'd1;
        if (MemWrite && (DataAdr == RES_ADR)) begin
          result_d = WriteData;
          rv_d     = 1'b1;
        end
        // A done store in the final allowed cycle takes priority over the abort.
        if (MemWrite && (DataAdr == DONE_ADR) && (WriteData == 32'd1)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == 32'(TIMEOUT - 1)) begin
          tout_d  = 1'b1;
          state_d = S_TOUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ld_ready      = (state_q == S_LOAD);
  assign cpu_reset     = (state_q != S_RUN);
  assign busy          = (state_q == S_LOAD) || (state_q == S_GAP) ||
                         (state_q == S_HOLD) || (state_q == S_RUN);
  assign Ext_MemWrite  = we_q;
  assign Ext_WriteData = wd_q;
  assign Ext_DataAdr   = adr_q;
  assign result        = result_q;
  assign result_valid  = rv_q;
  assign done          = done_q;
  assign timeout       = tout_q;

endmodule

// File: tb/tb_prog_run_sequencer.sv
// Bench for prog_run_sequencer: preload writes are scoreboarded by a monitor,
// run outcomes (result, done, timeout, reset behaviour) are checked inline.
module tb_prog_run_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = '0;
  logic        MemWrite = 1'b0;
  logic [31:0] WriteData = '0;
  logic [31:0] DataAdr = '0;
  logic        ld_ready, cpu_reset, Ext_MemWrite, result_valid, done, timeout, busy;
  logic [31:0] Ext_WriteData, Ext_DataAdr, result;

  prog_run_sequencer #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .cpu_reset(cpu_reset),
    .Ext_MemWrite(Ext_MemWrite), .Ext_WriteData(Ext_WriteData), .Ext_DataAdr(Ext_DataAdr),
    .MemWrite(MemWrite), .WriteData(WriteData), .DataAdr(DataAdr),
    .result(result), .result_valid(result_valid), .done(done),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  wr_t         exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          last_we_cyc = 0;
  logic [31:0] words[5];
  logic [31:0] adrs[5] = '{32'h0200_0000, 32'h0200_0004, 32'h0200_0008,
                           32'h0200_000c, 32'h0200_0010};
  logic [7:0]  pat = 8'b0110_1001;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Write monitor: every Ext write must match the next queued preload word.
  initial begin
    logic prev_we;
    wr_t  e;
    prev_we = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_we = 1'b0;
      end else begin
        if (Ext_MemWrite) begin
          chk("write_pulse_width", {31'd0, prev_we}, 32'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_write_adr", Ext_DataAdr, 32'hffff_ffff);
          end else begin
            e = exp_q.pop_front();
            chk("write_adr", Ext_DataAdr, e.adr);
            chk("write_dat", Ext_WriteData, e.dat);
          end
          last_we_cyc = cyc;
        end
        prev_we = Ext_MemWrite;
      end
    end
  end

  task automatic do_load(input bit bp, input int nwords);
    int i;
    int c;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("start_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("start_done_clr", {31'd0, done}, 32'd0);
    chk("start_tout_clr", {31'd0, timeout}, 32'd0);
    @(posedge clk); #1;
    i = 0;
    c = 0;
    while (i < nwords && c < 200) begin
      ld_valid = bp ? pat[c % 8] : 1'b1;
      ld_data  = ld_valid ? words[i] : 32'hdead_beef;
      @(negedge clk);
      if (ld_valid && ld_ready) begin
        exp_q.push_back({adrs[i], words[i]});
        i++;
      end
      @(posedge clk); #1;
      c++;
    end
    ld_valid = 1'b0;
    ld_data  = '0;
    chk("load_words_accepted", 32'(i), 32'(nwords));
  endtask

  task automatic wait_run();
    int c;
    c = 0;
    while (cpu_reset === 1'b1 && c < 60) begin
      @(negedge clk);
      c++;
    end
    chk("run_entry_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    chk("hold_len_after_gap", 32'(cyc - last_we_cyc), 32'd3);
  endtask

  task automatic cpu_store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    @(posedge clk); #1;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
  endtask

  task automatic completion();
    cpu_store(32'h0200_000c, 32'd89);
    cpu_store(32'h0000_0060, 32'd7);
    cpu_store(32'h0200_0010, 32'd1);
    @(negedge clk);
    chk("cmp_result", result, 32'd89);
    chk("cmp_result_valid", {31'd0, result_valid}, 32'd1);
    chk("cmp_done", {31'd0, done}, 32'd1);
    chk("cmp_timeout", {31'd0, timeout}, 32'd0);
    chk("cmp_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("cmp_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    words = '{32'd5, 32'd6, 32'd15, 32'd0, 32'd0};
    #12;
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_ext_we", {31'd0, Ext_MemWrite}, 32'd0);
    chk("rst_flags", {29'd0, done, timeout, result_valid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Preload then normal completion.
    do_load(1'b0, 5);
    wait_run();
    completion();

    // Done flag only honoured when the stored value is 1.
    do_load(1'b0, 5);
    wait_run();
    cpu_store(32'h0200_0010, 32'd0);
    @(negedge clk);
    chk("non1_done_low", {31'd0, done}, 32'd0);
    chk("non1_busy", {31'd0, busy}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    cpu_store(32'h0200_0010, 32'd1);
    @(negedge clk);
    chk("non1_done_high", {31'd0, done}, 32'd1);
    chk("non1_result_valid_clr", {31'd0, result_valid}, 32'd0);
    chk("non1_result_clr", result, 32'd0);

    // Backpressured preload, then a run with no stores that times out.
    words = '{32'h0000_00a1, 32'h0000_00b2, 32'h0000_00c3, 32'h0000_00d4, 32'h0000_00e5};
    do_load(1'b1, 5);
    wait_run();
    n = 1;
    while (cpu_reset === 1'b0 && n < 100) begin
      @(negedge clk);
      if (cpu_reset === 1'b0) n++;
    end
    chk("tout_run_cycles", 32'(n), 32'd16);
    chk("tout_flag", {31'd0, timeout}, 32'd1);
    chk("tout_done", {31'd0, done}, 32'd0);
    chk("tout_result_valid", {31'd0, result_valid}, 32'd0);
    chk("tout_busy", {31'd0, busy}, 32'd0);

    // Restart from TOUT, abort with async reset after two words.
    words = '{32'd5, 32'd6, 32'd15, 32'd0, 32'd0};
    do_load(1'b0, 2);
    @(negedge clk);
    @(posedge clk); #1;
    ld_valid = 1'b1;
    ld_data  = 32'h0000_0bad;
    @(negedge clk);
    chk("arst_pre_ld_ready", {31'd0, ld_ready}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_ext_we", {31'd0, Ext_MemWrite}, 32'd0);
    chk("arst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("arst_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    ld_valid = 1'b0;
    ld_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Fresh load must restart at the base address.
    do_load(1'b0, 5);
    wait_run();
    completion();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
